seg_display_scanner: RTL and testbench

Time-multiplexed scan controller for the board's 4-digit common-anode 7-segment display. Holds a 16-bit display value and rotates through its four hex nibbles at a programmable refresh rate. Drives the 4-bit digit code into the downstream hex-to-7-segment decoder, plus the active-low anode enables and decimal point. Supports optional leading-zero blanking and a one-cycle anode dead time between digits to prevent ghosting.

---
 rtl/seg_display_scanner.sv | 103 ++++++++++
 tb/tb_seg_display_scanner.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. A 16-bit shadow value is shown one hex nibble at a time. Each digit
// slot lasts CLK_DIV cycles. The first cycle of a slot is an anode dead cycle
// with all anodes off, which prevents ghosting. The remaining CLK_DIV-1 cycles
// drive the digit. Leading-zero blanking is optional.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   data_in   in   [15:0] value to display, nibble k -> digit k (0 = rightmost)
//   dp_in     in   [3:0]  decimal-point request per digit, active-high
//   load      in   capture strobe for data_in / dp_in
//   blank_lz  in   leading-zero blanking enable (level)
//   number    out  [3:0]  nibble of the scanned digit, to the hex decoder
//   an        out  [3:0]  anode enables, active-low, one-hot-low or all-high
//   dp        out  decimal-point segment, active-low
// -----------------------------------------------------------------------------
module seg_display_scanner #(
   parameter int CLK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   input  logic        blank_lz,
   output logic [3:0]  number,
   output logic [3:0]  an,
   output logic        dp
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   val_q, val_d;
   logic [3:0]    dpv_q, dpv_d;
   logic [3:0]    number_q, number_d;
   logic [3:0]    an_q, an_d;
   logic          dp_q, dp_d;
   logic          tick;
   logic [3:0]    blank;

   function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] k);
      return v[{k, 2'b00} +: 4];
   endfunction

   assign tick = (cnt_q == CW'(CLK_DIV - 1));

   // A digit is a leading zero when it and every digit above it are zero.
   // Digit 0 is always shown, so that a value of 0 still displays "0".
   assign blank[0] = 1'b0;
   assign blank[1] = blank_lz && (val_q[15:4]  == 12'h000);
   assign blank[2] = blank_lz && (val_q[15:8]  == 8'h00);
   assign blank[3] = blank_lz && (val_q[15:12] == 4'h0);

   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + CW'(1);
      idx_d    = tick ? idx_q + 2'd1 : idx_q;
      val_d    = load ? data_in : val_q;
      dpv_d    = load ? dp_in : dpv_q;
      number_d = nib(val_q, idx_q);
      an_d     = 4'b1111;
      dp_d     = 1'b1;
      if (tick) begin
         // Dead cycle. number is already presented for the next digit. It
         // uses the value being committed on this edge, so a load that
         // coincides with a tick is reflected immediately.
         number_d = nib(val_d, idx_d);
      end else if (!blank[idx_q]) begin
         an_d = ~(4'b0001 << idx_q);
         dp_d = ~dpv_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         idx_q    <= 2'd0;
         val_q    <= 16'h0000;
         dpv_q    <= 4'h0;
         number_q <= 4'h0;
         an_q     <= 4'b1110;
         dp_q     <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         val_q    <= val_d;
         dpv_q    <= dpv_d;
         number_q <= number_d;
         an_q     <= an_d;
         dp_q     <= dp_d;
      end
   end

   assign number = number_q;
   assign an     = an_q;
   assign dp     = dp_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
module tb_seg_display_scanner;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] data_in = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic [3:0]  number, an;
   logic        dp;

   int checks = 0;
   int errors = 0;

   // Reference model: the number of edges since reset release, plus the shadow
   // value and decimal-point state.
   int          e = 0;
   logic [15:0] m_val = 16'h0;
   logic [3:0]  m_dpv = 4'h0;

   seg_display_scanner #(.CLK_DIV(D)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
      .load(load), .blank_lz(blank_lz), .number(number), .an(an), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h expected %h", tag, e, got, exp);
      end
   endtask

   function automatic logic [3:0] nib(input logic [15:0] v, input int k);
      return 4'((v >> (4 * k)) & 16'h000F);
   endfunction

   // Called at a negedge. Drives the inputs, lets one rising edge pass,
   // predicts the outputs and checks them at the following negedge.
   task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p,
                       input logic bl);
      int k;
      logic [3:0]  x_an, x_num;
      logic        x_dp;
      logic [15:0] nv;
      load = ld; data_in = d; dp_in = p; blank_lz = bl;
      @(posedge clk);
      e++;
      // Edge e belongs to digit slot floor(e/D). Edge e is a tick edge
      // when e is a multiple of D.
      k    = (e / D) % 4;
      nv   = ld ? d : m_val;
      x_an = 4'b1111;
      x_dp = 1'b1;
      if (e % D == 0) begin
         x_num = nib(nv, k);
      end else begin
         x_num = nib(m_val, k);
         if (!(k != 0 && bl && (m_val >> (4 * k)) == 16'h0)) begin
            x_an[k] = 1'b0;
            x_dp    = ~m_dpv[k];
         end
      end
      if (ld) begin m_val = d; m_dpv = p; end
      @(negedge clk);
      chk("an", {12'h0, an}, {12'h0, x_an});
      chk("number", {12'h0, number}, {12'h0, x_num});
      chk("dp", {15'h0, dp}, {15'h0, x_dp});
      chk("an_onehot", {15'h0, ($countones(~an) <= 1)}, 16'h1);
   endtask

   task automatic idle(input int n, input logic bl);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, bl);
   endtask

   initial begin
      @(negedge clk);
      chk("rst_an", {12'h0, an}, 16'h000E);
      chk("rst_number", {12'h0, number}, 16'h0000);
      chk("rst_dp", {15'h0, dp}, 16'h0001);
      rst_n = 1'b1;

      // Basic scan of 1234.
      step(1'b1, 16'h1234, 4'h0, 1'b0);
      idle(8 * D, 1'b0);

      // Leading-zero blanking.
      step(1'b1, 16'h0050, 4'h0, 1'b1);
      idle(8 * D, 1'b1);
      step(1'b1, 16'h0000, 4'h0, 1'b1);
      idle(4 * D, 1'b1);

      // Decimal point on digit 2.
      step(1'b1, 16'hABCD, 4'b0100, 1'b0);
      idle(8 * D, 1'b0);

      // A load that lands on the tick that leaves digit 0.
      while (!(((e + 1) % D == 0) && (((e + 1) / D) % 4 == 1))) step(1'b0, 16'h0, 4'h0, 1'b0);
      step(1'b1, 16'hFFFF, 4'h0, 1'b0);
      chk("collide_an_dead", {12'h0, an}, 16'h000F);
      chk("collide_num", {12'h0, number}, 16'h000F);
      step(1'b0, 16'h0, 4'h0, 1'b0);
      chk("collide_an_d1", {12'h0, an}, 16'h000D);

      // Asynchronous reset while digit 2 is active.
      while (!(((e / D) % 4 == 2) && (e % D != 0))) step(1'b0, 16'h0, 4'h0, 1'b0);
      chk("pre_rst_an", {12'h0, an}, 16'h000B);
      #2 rst_n = 1'b0;
      #1;
      chk("async_an", {12'h0, an}, 16'h000E);
      chk("async_number", {12'h0, number}, 16'h0000);
      chk("async_dp", {15'h0, dp}, 16'h0001);
      load = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      e = 0; m_val = 16'h0; m_dpv = 4'h0;
      idle(D, 1'b0);
      chk("restart_d1_dead", {12'h0, an}, 16'h000F);

      // Random traffic.
      for (int i = 0; i < 1000; i++) begin
         logic [15:0] rd;
         rd = 16'($urandom);
         // Biasing toward small values gives leading zeros often.
         case ($urandom_range(0, 3))
            0: rd = rd & 16'h000F;
            1: rd = rd & 16'h00FF;
            default: ;
         endcase
         step(($urandom_range(0, 7) == 0), rd, 4'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
